// File: rtl/picorv32_wb_pkg.sv
// Shared types and constants for the PicoRV32-to-Wishbone bridge.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package picorv32_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } bridge_state_t;

    localparam logic [3:0]  WB_SEL_ALL       = 4'hF;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/picorv32_wb_bridge.sv
// Registered bridge from the PicoRV32 native memory port to a single-access Wishbone master.
// Latency: 3 cycles minimum (valid, stb+ack, ready); timeout force-completes after TIMEOUT_CYCLES in REQ.
// Backpressure: the slave stalls the core by withholding wb_ack; mem_ready is a one-cycle pulse.
module picorv32_wb_bridge
    import picorv32_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic        clk_core,
    input  logic        rst_core,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_addr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic        bus_err,
    output logic        err_instr
);

    // A zero timeout still gets a 1-bit counter so every vector has a legal width.
    localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);

    bridge_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             instr_q, instr_d;

    logic        mem_ready_d;
    logic [31:0] mem_rdata_d;
    logic        wb_cyc_d, wb_stb_d, wb_we_d;
    logic [3:0]  wb_sel_d;
    logic [31:0] wb_addr_d, wb_dat_o_d;
    logic        bus_err_d, err_instr_d;

    // Register every output so no input reaches an output combinationally.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            instr_q   <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            wb_we     <= 1'b0;
            wb_sel    <= '0;
            wb_addr   <= '0;
            wb_dat_o  <= '0;
            bus_err   <= 1'b0;
            err_instr <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            mem_ready <= mem_ready_d;
            mem_rdata <= mem_rdata_d;
            wb_cyc    <= wb_cyc_d;
            wb_stb    <= wb_stb_d;
            wb_we     <= wb_we_d;
            wb_sel    <= wb_sel_d;
            wb_addr   <= wb_addr_d;
            wb_dat_o  <= wb_dat_o_d;
            bus_err   <= bus_err_d;
            err_instr <= err_instr_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a state says otherwise.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        instr_d     = instr_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata;
        wb_cyc_d    = wb_cyc;
        wb_stb_d    = wb_stb;
        wb_we_d     = wb_we;
        wb_sel_d    = wb_sel;
        wb_addr_d   = wb_addr;
        wb_dat_o_d  = wb_dat_o;
        bus_err_d   = bus_err;
        err_instr_d = err_instr;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_valid) begin
                    state_d    = REQ;
                    instr_d    = mem_instr;
                    wb_addr_d  = mem_addr & 32'hFFFF_FFFC;
                    wb_dat_o_d = mem_wdata;
                    wb_we_d    = |mem_wstrb;
                    wb_sel_d   = (|mem_wstrb) ? mem_wstrb : WB_SEL_ALL;
                    wb_cyc_d   = 1'b1;
                    wb_stb_d   = 1'b1;
                end
            end
            REQ: begin
                // Ack is checked first so a late ack beats a coincident timeout.
                if (wb_ack) begin
                    state_d     = RESP;
                    mem_rdata_d = wb_dat_i;
                    mem_ready_d = 1'b1;
                    wb_cyc_d    = 1'b0;
                    wb_stb_d    = 1'b0;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    state_d     = RESP;
                    mem_rdata_d = ERR_DATA;
                    mem_ready_d = 1'b1;
                    bus_err_d   = 1'b1;
                    err_instr_d = instr_q;
                    wb_cyc_d    = 1'b0;
                    wb_stb_d    = 1'b0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                // The core is still releasing mem_valid here, so it is not sampled.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
